// File: rtl/scsi_initiator.sv
// scsi_initiator: single-command SCSI bus initiator.
// Selects a target and then services REQ/ACK handshakes until the target frees the bus.
module scsi_initiator #(
    parameter logic [2:0]  INIT_ID     = 3'd7,
    parameter logic [23:0] SEL_TIMEOUT = 24'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bsy,
    input  logic        msg,
    input  logic        cd,
    input  logic        io,
    input  logic        req,
    input  logic [7:0]  din,
    output logic        sel,
    output logic        atn,
    output logic        ack,
    output logic [7:0]  dout,
    input  logic        start,
    input  logic [2:0]  target_id,
    input  logic [79:0] cdb,
    input  logic [3:0]  cdb_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_strobe,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  status,
    output logic [31:0] byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        BUSFREE,
        SELECT,
        WAIT_REQ,
        ACK_HI,
        FINISH
    } state_t;

    localparam logic [2:0] PH_DOUT = 3'b000;
    localparam logic [2:0] PH_DIN  = 3'b001;
    localparam logic [2:0] PH_CMD  = 3'b010;
    localparam logic [2:0] PH_STAT = 3'b011;
    localparam logic [2:0] PH_MSGI = 3'b111;

    state_t      state;
    logic        req_q;
    logic [2:0]  ph_q;
    logic [7:0]  din_q;
    logic [2:0]  xfer_ph;
    logic [7:0]  in_byte;
    logic [2:0]  tid_q;
    logic [79:0] cdb_q;
    logic [3:0]  len_q;
    logic [3:0]  idx;
    logic [23:0] tmo_cnt;
    logic [7:0]  sel_mask;

    assign sel_mask = (8'd1 << tid_q) | (8'd1 << INIT_ID);
    assign atn      = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            ph_q      <= 3'b000;
            din_q     <= 8'h00;
            xfer_ph   <= 3'b000;
            in_byte   <= 8'h00;
            tid_q     <= 3'd0;
            cdb_q     <= '0;
            len_q     <= 4'd0;
            idx       <= 4'd0;
            tmo_cnt   <= 24'd0;
            sel       <= 1'b0;
            ack       <= 1'b0;
            dout      <= 8'h00;
            wr_ready  <= 1'b0;
            rd_data   <= 8'h00;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            status    <= 8'h00;
            byte_cnt  <= 32'd0;
        end else begin
            // Bus handshake lines are registered once; every reaction keys off req_q.
            req_q     <= req;
            ph_q      <= {msg, cd, io};
            din_q     <= din;
            wr_ready  <= 1'b0;
            rd_strobe <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        tid_q    <= target_id;
                        cdb_q    <= cdb;
                        len_q    <= cdb_len;
                        idx      <= 4'd0;
                        byte_cnt <= 32'd0;
                        status   <= 8'h00;
                        busy     <= 1'b1;
                        state    <= BUSFREE;
                    end
                end

                BUSFREE: begin
                    if (!bsy) begin
                        dout    <= sel_mask;
                        sel     <= 1'b1;
                        tmo_cnt <= 24'd0;
                        state   <= SELECT;
                    end
                end

                SELECT: begin
                    if (bsy) begin
                        sel   <= 1'b0;
                        dout  <= 8'h00;
                        state <= WAIT_REQ;
                    end else if (tmo_cnt >= SEL_TIMEOUT - 24'd1) begin
                        sel     <= 1'b0;
                        dout    <= 8'h00;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end

                WAIT_REQ: begin
                    if (!bsy) begin
                        state <= FINISH;
                    end else if (req_q) begin
                        xfer_ph <= ph_q;
                        unique case (ph_q)
                            PH_CMD: begin
                                // cdb_q shifts out MSB-first; past cdb_len the bus sees zeros.
                                dout  <= (idx < len_q) ? cdb_q[79:72] : 8'h00;
                                cdb_q <= {cdb_q[71:0], 8'h00};
                                if (idx != 4'hF)
                                    idx <= idx + 4'd1;
                                ack   <= 1'b1;
                                state <= ACK_HI;
                            end
                            PH_DOUT: begin
                                if (wr_valid) begin
                                    dout     <= wr_data;
                                    wr_ready <= 1'b1;
                                    ack      <= 1'b1;
                                    state    <= ACK_HI;
                                end
                            end
                            PH_DIN, PH_STAT, PH_MSGI: begin
                                in_byte <= din_q;
                                ack     <= 1'b1;
                                state   <= ACK_HI;
                            end
                            default: begin
                                dout  <= 8'h00;
                                ack   <= 1'b1;
                                state <= ACK_HI;
                            end
                        endcase
                    end
                end

                ACK_HI: begin
                    if (!bsy) begin
                        ack   <= 1'b0;
                        state <= FINISH;
                    end else if (!req_q) begin
                        ack   <= 1'b0;
                        state <= WAIT_REQ;
                        if (xfer_ph == PH_DIN) begin
                            rd_strobe <= 1'b1;
                            rd_data   <= in_byte;
                        end
                        if (xfer_ph == PH_DIN || xfer_ph == PH_DOUT)
                            byte_cnt <= byte_cnt + 32'd1;
                        if (xfer_ph == PH_STAT)
                            status <= in_byte;
                    end
                end

                FINISH: begin
                    sel   <= 1'b0;
                    ack   <= 1'b0;
                    dout  <= 8'h00;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
